// File: rtl/cm0ik_misc_delay_sched.sv
// Purpose : round-robin scheduler sharing one countdown timer among NREQ requesters; grantee gets a done pulse.
// Latency : grant on edge k, done on edge k+max(delay_val,1); at least one idle cycle before the next grant.
// Backpressure: requesters hold req until done; dropping req or en during COUNT aborts without a done pulse.
module cm0ik_misc_delay_sched #(
    parameter int NREQ = 4,
    parameter int CW   = 8
) (
    input  logic            fclk,
    input  logic            hresetn,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    input  logic [CW-1:0]   delay_val,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] done,
    output logic            busy,
    output logic [CW-1:0]   cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   rr_ptr_nxt;
    logic [NREQ-1:0] gnt_nxt;
    logic [NREQ-1:0] done_nxt;
    logic [CW-1:0]   cnt_nxt;
    logic            busy_nxt;

    logic            win_vld;
    logic [PW-1:0]   win_idx;
    logic [NREQ-1:0] win_oh;

    // Round-robin winner: first requester found searching upward from rr_ptr+1, wrapping at NREQ.
    always_comb begin
        int            j;
        logic [PW-1:0] cand;
        win_vld = 1'b0;
        win_idx = '0;
        j       = 0;
        cand    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            cand = PW'(j);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
        win_oh = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
    end

    // Next-state and next-output logic; outputs are computed here and registered below.
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        gnt_nxt    = gnt;
        done_nxt   = '0;
        cnt_nxt    = cnt;
        busy_nxt   = busy;
        case (state)
            IDLE: begin
                gnt_nxt  = '0;
                cnt_nxt  = '0;
                busy_nxt = 1'b0;
                if (en && win_vld) begin
                    state_nxt  = COUNT;
                    gnt_nxt    = win_oh;
                    cnt_nxt    = delay_val;
                    rr_ptr_nxt = win_idx;
                    busy_nxt   = 1'b1;
                end
            end
            COUNT: begin
                if (!en || ((req & gnt) == '0)) begin
                    // Abort: requester gave up or block disabled, no done pulse.
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                end else if (cnt <= CW'(1)) begin
                    // Leaving at 1 (or 0) keeps the counter from ever wrapping.
                    state_nxt = DONE;
                    done_nxt  = gnt;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            DONE: begin
                // Single-cycle state; en and req are deliberately ignored here.
                state_nxt = IDLE;
                gnt_nxt   = '0;
                cnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                cnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset parks the pointer so requester 0 wins first.
    always_ff @(posedge fclk or negedge hresetn) begin
        if (!hresetn) begin
            state  <= IDLE;
            rr_ptr <= PW'(NREQ - 1);
            gnt    <= '0;
            done   <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            gnt    <= gnt_nxt;
            done   <= done_nxt;
            cnt    <= cnt_nxt;
            busy   <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_cm0ik_misc_delay_sched.sv
// Purpose : directed bench for cm0ik_misc_delay_sched with a done-pulse scoreboard.
// Latency : expected done entries carry the edge number on which the pulse must appear.
// Backpressure: n/a (bench drives req/en directly).
module tb_cm0ik_misc_delay_sched;

    logic       fclk      = 1'b0;
    logic       hresetn   = 1'b0;
    logic       en        = 1'b0;
    logic [3:0] req       = 4'b0000;
    logic [7:0] delay_val = 8'd0;
    logic [3:0] gnt;
    logic [3:0] done;
    logic       busy;
    logic [7:0] cnt;

    typedef struct {
        logic [3:0] dat;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   prev;
    int   k;
    int   n;
    int   d;
    logic [3:0] rr_seq [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    int         t3_d   [3] = '{0, 1, 255};

    cm0ik_misc_delay_sched #(.NREQ(4), .CW(8)) dut (
        .fclk      (fclk),
        .hresetn   (hresetn),
        .en        (en),
        .req       (req),
        .delay_val (delay_val),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .cnt       (cnt)
    );

    always #5 fclk = ~fclk;

    // Edge counter used to timestamp grants and done pulses.
    always @(posedge fclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    // Expect a grant on the next edge; optionally queue the done pulse it should produce.
    task automatic grant_next(input string tag, input logic [3:0] exp, input int dly, input bit push);
        exp_t t;
        tick();
        check(tag, gnt, exp);
        check({tag, "_cnt"}, cnt, dly);
        check({tag, "_busy"}, busy, 1);
        if (push) begin
            t.dat = exp;
            t.cyc = cyc + ((dly < 1) ? 1 : dly);
            sb.push_back(t);
        end
    endtask

    // Done monitor and invariant checks, sampled on the falling edge.
    always @(negedge fclk) begin
        if (hresetn) begin
            check("inv_gnt_onehot0", $onehot0(gnt), 1);
            check("inv_done_in_gnt", done & ~gnt, 0);
            if (done != 4'b0000) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", done, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_val", done, mon_e.dat);
                    check("done_cyc", cyc, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        repeat (3) tick();
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", cnt, 0);
        hresetn = 1'b1;
        tick();
        check("idle_en0_gnt", gnt, 0);

        // Test 1: first grant, countdown 3,2,1, done on k+3; late delay_val change ignored
        en = 1'b1; req = 4'b1111; delay_val = 8'd3;
        grant_next("t1_gnt", 4'b0001, 3, 1'b1);
        delay_val = 8'd9;
        tick(); check("t1_cnt2", cnt, 2); check("t1_busy1", busy, 1);
        tick(); check("t1_cnt1", cnt, 1); check("t1_busy2", busy, 1);
        tick(); check("t1_done", done, 4'b0001); check("t1_done_gnt", gnt, 4'b0001);
        check("t1_busy3", busy, 1);
        req = 4'b1110;
        tick();
        check("t1_exit_gnt", gnt, 0); check("t1_exit_done", done, 0);
        check("t1_exit_busy", busy, 0); check("t1_exit_cnt", cnt, 0);

        // Test 2: round robin with delay 1, grants every 3 edges
        req = 4'b1111; delay_val = 8'd1; prev = 0;
        for (int i = 0; i < 5; i++) begin
            grant_next("t2_gnt", rr_seq[i], 1, 1'b1);
            if (i > 0) check("t2_spacing", cyc - prev, 3);
            prev = cyc;
            tick();
            check("t2_done", done, rr_seq[i]);
            req = req & ~rr_seq[i];
            tick();
            check("t2_idle", gnt, 0);
            req = req | rr_seq[i];
        end

        // Test 3: delays 0, 1, 255 with no counter wrap
        req = 4'b0000;
        tick();
        for (int i = 0; i < 3; i++) begin
            d = t3_d[i];
            req = 4'b0100; delay_val = 8'(d);
            grant_next("t3_gnt", 4'b0100, d, 1'b1);
            k = cyc;
            while (cyc < k + ((d < 1) ? 1 : d)) begin
                check("t3_cnt", cnt, d - (cyc - k));
                tick();
            end
            check("t3_done", done, 4'b0100);
            check("t3_done_cnt", cnt, (d == 0) ? 0 : 1);
            req = 4'b0000;
            tick();
            check("t3_exit_busy", busy, 0);
            check("t3_exit_cnt", cnt, 0);
        end

        // Test 4: withdraw req[2] at cnt=5, pending req[3] granted next edge
        req = 4'b0100; delay_val = 8'd10;
        grant_next("t4_gnt2", 4'b0100, 10, 1'b0);
        repeat (5) tick();
        check("t4_cnt5", cnt, 5);
        req = 4'b1000; delay_val = 8'd2;
        tick();
        check("t4_abort_gnt", gnt, 0); check("t4_abort_busy", busy, 0);
        check("t4_abort_done", done, 0); check("t4_abort_cnt", cnt, 0);
        grant_next("t4_gnt3", 4'b1000, 2, 1'b1);
        tick(); tick();
        check("t4_done", done, 4'b1000);
        req = 4'b0000;
        tick();
        check("t4_exit_busy", busy, 0);

        // Test 5: enable control
        en = 1'b0; req = 4'b0011;
        repeat (20) begin
            tick();
            check("t5_nogrant", gnt, 0);
        end
        en = 1'b1; delay_val = 8'd6;
        grant_next("t5_gnt0", 4'b0001, 6, 1'b0);
        tick(); tick();
        en = 1'b0;
        tick();
        check("t5_abort_gnt", gnt, 0); check("t5_abort_busy", busy, 0);
        en = 1'b1; delay_val = 8'd2;
        grant_next("t5_gnt1", 4'b0010, 2, 1'b1);
        tick(); tick();
        check("t5_done", done, 4'b0010);
        en = 1'b0;
        tick();
        check("t5_exit_gnt", gnt, 0); check("t5_exit_done", done, 0);
        check("t5_exit_busy", busy, 0);
        tick();
        check("t5_en0_nogrant", gnt, 0);
        req = 4'b0000;

        // Test 6: asynchronous reset mid-count, pointer restarts at NREQ-1
        en = 1'b1; req = 4'b0001; delay_val = 8'd20;
        grant_next("t6_gnt", 4'b0001, 20, 1'b1);
        n = 0;
        while (cnt != 8'd7 && n < 30) begin
            tick();
            n++;
        end
        check("t6_cnt7", cnt, 7);
        #3;
        hresetn = 1'b0;
        #1;
        check("t6_rst_gnt", gnt, 0); check("t6_rst_done", done, 0);
        check("t6_rst_busy", busy, 0); check("t6_rst_cnt", cnt, 0);
        sb.delete();
        req = 4'b1001; delay_val = 8'd2;
        #2;
        hresetn = 1'b1;
        grant_next("t6_ptr_gnt", 4'b0001, 2, 1'b1);
        tick(); tick();
        check("t6_done0", done, 4'b0001);
        req = 4'b1000;
        tick();
        check("t6_idle", gnt, 0);
        delay_val = 8'd1;
        grant_next("t6_gnt3", 4'b1000, 1, 1'b1);
        tick();
        check("t6_done3", done, 4'b1000);
        req = 4'b0000;
        tick();
        tick();

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
